// File: rtl/data_write_buffer.sv
// Store FIFO between the merged data port and cpu_axi_interface: stores retire after one cycle and drain in order.
// Optional macro DWB_ADDR_CHECK_EN lets reads bypass buffered stores to other words.
module data_write_buffer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        up_req,
  input  logic        up_wr,
  input  logic [1:0]  up_size,
  input  logic [31:0] up_addr,
  input  logic [31:0] up_wdata,
  output logic [31:0] up_rdata,
  output logic        up_addr_ok,
  output logic        up_data_ok,
  output logic        dn_req,
  output logic        dn_wr,
  output logic [1:0]  dn_size,
  output logic [31:0] dn_addr,
  output logic [31:0] dn_wdata,
  input  logic [31:0] dn_rdata,
  input  logic        dn_addr_ok,
  input  logic        dn_data_ok,
  output logic        buf_empty
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DRAIN      = 2'd1,
    DRAIN_WAIT = 2'd2,
    READ_WAIT  = 2'd3
  } state_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [31:0]      fifo_addr_r [DEPTH];
  logic [1:0]       fifo_size_r [DEPTH];
  logic [31:0]      fifo_data_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [PTR_W:0]   count_r;
  logic             wr_ack_r;
  logic             rd_pend_r;

  logic full_s;
  logic empty_s;
  logic push_s;
  logic pop_s;
  logic conflict_s;
  logic rd_elig_s;
  logic rd_issue_s;
  logic rd_done_s;

  assign full_s     = (count_r == FULL_CNT);
  assign empty_s    = (count_r == {(PTR_W+1){1'b0}});
  assign push_s     = up_req & up_wr & ~full_s & ~rd_pend_r;
  assign pop_s      = (state_r == DRAIN_WAIT) & dn_data_ok;
  assign rd_elig_s  = up_req & ~up_wr & (state_r == IDLE) & ~wr_ack_r & ~rd_pend_r & ~conflict_s;
  assign rd_issue_s = rd_elig_s & dn_addr_ok;
  assign rd_done_s  = (state_r == READ_WAIT) & dn_data_ok;

`ifdef DWB_ADDR_CHECK_EN
  logic [PTR_W-1:0] rel_s;

  // Word-address match against every live entry; the draining head is still live until popped
  always_comb begin
    conflict_s = 1'b0;
    rel_s      = {PTR_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      rel_s      = PTR_W'(i) - head_r;
      conflict_s = conflict_s |
                   (({1'b0, rel_s} < count_r) && (fifo_addr_r[i][31:2] == up_addr[31:2]));
    end
  end
`else
  assign conflict_s = ~empty_s;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: reads win in IDLE, otherwise any buffered or incoming store starts a drain
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (rd_elig_s) begin
          if (dn_addr_ok) state_nxt_s = READ_WAIT;
          else            state_nxt_s = IDLE;
        end else if (~empty_s | push_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRAIN: begin
        if (dn_addr_ok) state_nxt_s = DRAIN_WAIT;
        else            state_nxt_s = DRAIN;
      end
      DRAIN_WAIT: begin
        if (dn_data_ok) state_nxt_s = IDLE;
        else            state_nxt_s = DRAIN_WAIT;
      end
      READ_WAIT: begin
        if (dn_data_ok) state_nxt_s = IDLE;
        else            state_nxt_s = READ_WAIT;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Downstream request outputs
  always_comb begin
    dn_req   = 1'b0;
    dn_wr    = 1'b0;
    dn_size  = 2'd0;
    dn_addr  = 32'h0000_0000;
    dn_wdata = 32'h0000_0000;
    case (state_r)
      IDLE: begin
        if (rd_elig_s) begin
          dn_req  = 1'b1;
          dn_size = up_size;
          dn_addr = up_addr;
        end else begin
          dn_req  = 1'b0;
        end
      end
      DRAIN: begin
        dn_req   = 1'b1;
        dn_wr    = 1'b1;
        dn_size  = fifo_size_r[head_r];
        dn_addr  = fifo_addr_r[head_r];
        dn_wdata = fifo_data_r[head_r];
      end
      DRAIN_WAIT: dn_req = 1'b0;
      READ_WAIT:  dn_req = 1'b0;
      default:    dn_req = 1'b0;
    endcase
  end

  assign up_addr_ok = push_s | rd_issue_s;
  assign up_data_ok = wr_ack_r | rd_done_s;
  assign up_rdata   = rd_done_s ? dn_rdata : 32'h0000_0000;
  assign buf_empty  = empty_s & (state_r == IDLE) & ~wr_ack_r;

  // Pointers, occupancy and handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r    <= {PTR_W{1'b0}};
      tail_r    <= {PTR_W{1'b0}};
      count_r   <= {(PTR_W+1){1'b0}};
      wr_ack_r  <= 1'b0;
      rd_pend_r <= 1'b0;
    end else begin
      if (push_s) tail_r <= tail_r + PTR_W'(1);
      else        tail_r <= tail_r;
      if (pop_s)  head_r <= head_r + PTR_W'(1);
      else        head_r <= head_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
      wr_ack_r <= push_s;
      if (rd_issue_s)     rd_pend_r <= 1'b1;
      else if (rd_done_s) rd_pend_r <= 1'b0;
      else                rd_pend_r <= rd_pend_r;
    end
  end

  // Entry storage; contents need no reset since count gates every use
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_addr_r[tail_r] <= up_addr;
      fifo_size_r[tail_r] <= up_size;
      fifo_data_r[tail_r] <= up_wdata;
    end
  end

endmodule

// File: tb/tb_data_write_buffer.sv
// Self-checking bench for data_write_buffer: directed vectors, corner sequences and a
// randomized run against a memory-level reference model with a sram-like slave.
module tb_data_write_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        up_req, up_wr;
  logic [1:0]  up_size;
  logic [31:0] up_addr, up_wdata, up_rdata;
  logic        up_addr_ok, up_data_ok;
  logic        dn_req, dn_wr;
  logic [1:0]  dn_size;
  logic [31:0] dn_addr, dn_wdata, dn_rdata;
  logic        dn_addr_ok, dn_data_ok;
  logic        buf_empty;

  always #5 clk = ~clk;

  data_write_buffer #(.DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .rst(rst),
    .up_req(up_req), .up_wr(up_wr), .up_size(up_size), .up_addr(up_addr),
    .up_wdata(up_wdata), .up_rdata(up_rdata), .up_addr_ok(up_addr_ok), .up_data_ok(up_data_ok),
    .dn_req(dn_req), .dn_wr(dn_wr), .dn_size(dn_size), .dn_addr(dn_addr), .dn_wdata(dn_wdata),
    .dn_rdata(dn_rdata), .dn_addr_ok(dn_addr_ok), .dn_data_ok(dn_data_ok), .buf_empty(buf_empty)
  );

  typedef struct { logic wr; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata; } op_t;
  typedef struct { logic rd; logic [31:0] data; int cyc; } resp_t;
  typedef struct { logic [31:0] addr; logic [1:0] size; logic [31:0] wdata;
                   logic [31:0] exp_addr; logic [1:0] exp_size; logic [31:0] exp_wdata; } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  op_t         mq[$];
  op_t         dnq[$];
  resp_t       rq[$];
  logic [29:0] outst[$];
  logic [31:0] ref_mem [logic [29:0]];
  logic [31:0] smem [logic [29:0]];

  logic        sl_busy, sl_rd, sl_hold, presenting, last_buf_empty, bypass_seen;
  logic [31:0] sl_rdata;
  int          sl_cnt, sl_pct, up_pct, lat_lo, lat_hi, wr_acc;
  int          first_done_cyc, last_acc_cyc, wr_done_cyc, rd_issue_cyc;

  function automatic logic [31:0] mem_init(input logic [29:0] w);
    return {w[15:0], 16'hA5C3} ^ 32'h1234_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : mem_init(w);
  endfunction

  function automatic logic [31:0] slv_rd(input logic [29:0] w);
    return smem.exists(w) ? smem[w] : mem_init(w);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle_inputs();
    up_req = 1'b0; up_wr = 1'b0; up_size = 2'd0; up_addr = 32'h0; up_wdata = 32'h0;
    dn_rdata = 32'h0; dn_addr_ok = 1'b0; dn_data_ok = 1'b0;
  endtask

  task automatic clear_model();
    mq.delete(); dnq.delete(); rq.delete(); outst.delete();
    ref_mem.delete(); smem.delete();
    sl_busy = 1'b0; sl_rd = 1'b0; sl_hold = 1'b0; presenting = 1'b0; sl_cnt = 0;
    wr_acc = 0; first_done_cyc = -1; last_acc_cyc = -1; wr_done_cyc = -1; rd_issue_cyc = -1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
  endtask

  // One cycle of master + slave + scoreboard; starts and ends 1 time unit after a rising edge
  task automatic engine_cycle();
    logic  up_acc, dn_acc;
    op_t   o, e;
    resp_t r;
    logic [29:0] w;
    logic  hit;
    if (!presenting && mq.size() > 0 && $urandom_range(0, 99) < up_pct) presenting = 1'b1;
    if (presenting) begin
      up_req = 1'b1; up_wr = mq[0].wr; up_size = mq[0].size; up_addr = mq[0].addr; up_wdata = mq[0].wdata;
    end else begin
      up_req = 1'b0; up_wr = 1'b0; up_size = 2'd0; up_addr = 32'h0; up_wdata = 32'h0;
    end
    if (sl_busy && sl_cnt == 0) begin
      dn_data_ok = 1'b1; dn_rdata = sl_rdata;
    end else begin
      dn_data_ok = 1'b0; dn_rdata = $urandom();
    end
    dn_addr_ok = !sl_busy && !sl_hold && ($urandom_range(0, 99) < sl_pct);
    #1;
    up_acc = up_req && up_addr_ok;
    dn_acc = dn_req && dn_addr_ok;
    last_buf_empty = buf_empty;
    if (up_data_ok) begin
      chk("resp_pending", 32'(rq.size() != 0), 32'd1);
      if (rq.size() != 0) begin
        r = rq.pop_front();
        if (r.rd) chk("read_rdata", up_rdata, r.data);
        else begin
          chk("write_ack_rdata", up_rdata, r.data);
          chk("write_ack_latency", 32'(cyc - r.cyc), 32'd1);
        end
      end
    end
    if (dn_data_ok) begin
      sl_busy = 1'b0;
      if (!sl_rd) begin
        if (outst.size() != 0) w = outst.pop_front();
        wr_done_cyc = cyc;
        if (first_done_cyc < 0) first_done_cyc = cyc;
      end
    end else if (sl_busy) begin
      sl_cnt--;
    end
    if (dn_acc) begin
      if (dn_wr) begin
        chk("dn_write_expected", 32'(dnq.size() != 0), 32'd1);
        if (dnq.size() != 0) begin
          e = dnq.pop_front();
          chk("dn_write_addr", dn_addr, e.addr);
          chk("dn_write_size", dn_size, e.size);
          chk("dn_write_data", dn_wdata, e.wdata);
        end
        smem[dn_addr[31:2]] = dn_wdata;
      end else begin
        chk("read_fwd_addr", dn_addr, (mq.size() != 0) ? mq[0].addr : 32'hFFFF_FFFF);
        chk("read_fwd_accept", up_addr_ok, 1'b1);
        hit = 1'b0;
        foreach (outst[k]) if (outst[k] == dn_addr[31:2]) hit = 1'b1;
`ifdef DWB_ADDR_CHECK_EN
        chk("read_passed_same_word_store", hit, 1'b0);
        if (outst.size() != 0) bypass_seen = 1'b1;
`else
        chk("read_passed_store", 32'(outst.size()) | 32'(hit), 32'd0);
`endif
        sl_rdata = slv_rd(dn_addr[31:2]);
        rd_issue_cyc = cyc;
      end
      sl_busy = 1'b1;
      sl_rd   = !dn_wr;
      sl_cnt  = $urandom_range(lat_lo, lat_hi) - 1;
    end
    if (up_acc) begin
      o = mq.pop_front();
      presenting = 1'b0;
      last_acc_cyc = cyc;
      if (o.wr) begin
        ref_mem[o.addr[31:2]] = o.wdata;
        rq.push_back('{1'b0, 32'h0, cyc});
        dnq.push_back(o);
        outst.push_back(o.addr[31:2]);
        wr_acc++;
      end else begin
        rq.push_back('{1'b1, ref_rd(o.addr[31:2]), cyc});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_until_done(input string name, input int budget);
    int   n;
    logic fin;
    n = 0;
    fin = 1'b0;
    while (!fin && n < budget) begin
      engine_cycle();
      n++;
      fin = (mq.size() == 0) && (rq.size() == 0) && (dnq.size() == 0) && !sl_busy && last_buf_empty;
    end
    chk({name, "_completed"}, fin, 1'b1);
  endtask

  task automatic vec_test(input vec_t v);
    idle_inputs();
    up_req = 1'b1; up_wr = 1'b1; up_size = v.size; up_addr = v.addr; up_wdata = v.wdata;
    #1;
    chk("vec_addr_ok", up_addr_ok, 1'b1);
    chk("vec_dn_req_before", dn_req, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    dn_addr_ok = 1'b1;
    #1;
    chk("vec_data_ok", up_data_ok, 1'b1);
    chk("vec_dn_req", dn_req, 1'b1);
    chk("vec_dn_wr", dn_wr, 1'b1);
    chk("vec_dn_addr", dn_addr, v.exp_addr);
    chk("vec_dn_size", dn_size, v.exp_size);
    chk("vec_dn_wdata", dn_wdata, v.exp_wdata);
    @(posedge clk); #1;
    dn_addr_ok = 1'b0; dn_data_ok = 1'b1;
    #1;
    chk("vec_wait_dn_req", dn_req, 1'b0);
    chk("vec_wait_busy", buf_empty, 1'b0);
    chk("vec_single_ack", up_data_ok, 1'b0);
    @(posedge clk); #1;
    dn_data_ok = 1'b0;
    #1;
    chk("vec_buf_empty", buf_empty, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[3];
    op_t  o;
    int   n;
    vecs[0] = '{32'h0000_1000, 2'd2, 32'hDEAD_BEEF, 32'h0000_1000, 2'd2, 32'hDEAD_BEEF};
    vecs[1] = '{32'h0000_001F, 2'd0, 32'h0000_00AA, 32'h0000_001F, 2'd0, 32'h0000_00AA};
    vecs[2] = '{32'h0000_0A02, 2'd1, 32'h1234_5678, 32'h0000_0A02, 2'd1, 32'h1234_5678};
    up_pct = 100; sl_pct = 100; lat_lo = 1; lat_hi = 1; bypass_seen = 1'b0;
    last_buf_empty = 1'b0;

    do_reset();
    #1;
    chk("rst_up_addr_ok", up_addr_ok, 1'b0);
    chk("rst_up_data_ok", up_data_ok, 1'b0);
    chk("rst_up_rdata", up_rdata, 32'h0);
    chk("rst_dn_req", dn_req, 1'b0);
    chk("rst_dn_wr", dn_wr, 1'b0);
    chk("rst_dn_size", dn_size, 2'd0);
    chk("rst_dn_addr", dn_addr, 32'h0);
    chk("rst_dn_wdata", dn_wdata, 32'h0);
    chk("rst_buf_empty", buf_empty, 1'b1);
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) vec_test(vecs[i]);

    // Nine stores against a stalled memory: eight fill the buffer, the ninth waits for the first retire
    do_reset();
    for (int i = 0; i < 9; i++) mq.push_back('{1'b1, 2'd2, 32'h0000_5000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i)});
    sl_hold = 1'b1;
    repeat (12) engine_cycle();
    chk("full_accepted", 32'(wr_acc), 32'd8);
    chk("full_blocks_ninth", up_addr_ok, 1'b0);
    sl_hold = 1'b0;
    run_until_done("full_drain", 200);
    chk("ninth_after_first_retire", 32'(last_acc_cyc - first_done_cyc), 32'd1);

    // Store then read of the same word with 3-cycle memory latency
    do_reset();
    lat_lo = 3; lat_hi = 3;
    mq.push_back('{1'b1, 2'd2, 32'h0000_2000, 32'h5EED_2000});
    mq.push_back('{1'b0, 2'd2, 32'h0000_2000, 32'h0});
    run_until_done("store_read", 100);
    chk("read_after_store_retired", 32'(rd_issue_cyc > wr_done_cyc), 32'd1);

`ifdef DWB_ADDR_CHECK_EN
    do_reset();
    lat_lo = 3; lat_hi = 3; bypass_seen = 1'b0;
    for (int i = 0; i < 3; i++) mq.push_back('{1'b1, 2'd2, 32'h0000_3000 + 32'(i * 4), 32'hB0B0_0000 + 32'(i)});
    mq.push_back('{1'b0, 2'd2, 32'h0000_4000, 32'h0});
    mq.push_back('{1'b0, 2'd2, 32'h0000_3004, 32'h0});
    run_until_done("addr_check", 200);
    chk("read_bypass_seen", bypass_seen, 1'b1);
`endif

    // Reset while a drain is waiting on memory with four entries buffered
    do_reset();
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 4; i++) mq.push_back('{1'b1, 2'd2, 32'h0000_7000 + 32'(i * 4), 32'h7777_0000 + 32'(i)});
    sl_hold = 1'b1;
    repeat (6) engine_cycle();
    sl_hold = 1'b0; lat_lo = 20; lat_hi = 20;
    n = 0;
    while (!sl_busy && n < 20) begin
      engine_cycle();
      n++;
    end
    chk("drain_in_flight", sl_busy, 1'b1);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    #1;
    chk("midrst_dn_req", dn_req, 1'b0);
    chk("midrst_buf_empty", buf_empty, 1'b1);
    chk("midrst_data_ok", up_data_ok, 1'b0);
    @(posedge clk); #1;
    lat_lo = 1; lat_hi = 2;
    mq.push_back('{1'b1, 2'd2, 32'h0000_6000, 32'h6000_ABCD});
    run_until_done("post_reset_store", 50);

    // Randomized mix over a small word pool so reads often hit buffered stores
    do_reset();
    up_pct = 70; sl_pct = 60; lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 300; i++) begin
      o.wr    = ($urandom_range(0, 99) < 65);
      o.size  = 2'd2;
      o.addr  = 32'h0000_0100 + 32'($urandom_range(0, 15) * 4);
      o.wdata = o.wr ? $urandom() : 32'h0;
      mq.push_back(o);
    end
    run_until_done("random", 20000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_write_buffer.md
Name: data_write_buffer

Overview:
- FIFO write buffer on the data path, between the merged cached/uncached data port (output of bridge_2x1) and the data port of cpu_axi_interface.
- Retires stores to the core after one cycle, then drains them in order to memory.
- Reads are held until no older buffered store can conflict, then passed through.
- Both sides use the team's sram-like protocol: req/wr/size/addr/wdata/addr_ok/data_ok/rdata.

Parameters:
- DEPTH, 8, number of buffered stores; power of two, at least 2.
- PTR_W, 3, log2(DEPTH); pointer width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- up_req  in  1  upstream request
- up_wr  in  1  1 = write, 0 = read
- up_size  in  2  0 = byte, 1 = half, 2 = word
- up_addr  in  32  physical address
- up_wdata  in  32  write data
- up_rdata  out  32  read data
- up_addr_ok  out  1  request accepted this cycle
- up_data_ok  out  1  one pulse per accepted request, in acceptance order
- dn_req  out  1  downstream request
- dn_wr  out  1  downstream write/read select
- dn_size  out  2  downstream size
- dn_addr  out  32  downstream address
- dn_wdata  out  32  downstream write data
- dn_rdata  in  32  downstream read data
- dn_addr_ok  in  1  downstream accept
- dn_data_ok  in  1  downstream completion
- buf_empty  out  1  FIFO empty and no downstream transaction in flight (for sync/cache ops)

Behaviour:

Reset:
- rst=1 at a clock edge sets: FIFO pointers and count to 0, state to IDLE, wr_ack_q=0, rd_pend=0.
- All outputs 0 except buf_empty=1.
- A downstream transaction in flight at reset is abandoned. rst is asserted only with the whole core, so no data_ok is expected afterwards.

Storage:
- DEPTH entries of {addr[31:0], size[1:0], wdata[31:0]}.
- Circular head/tail pointers of PTR_W bits, wrapping modulo DEPTH.
- count is PTR_W+1 bits. full = (count==DEPTH), empty = (count==0).

Upstream writes:
- up_addr_ok = up_req & up_wr & ~full & ~rd_pend.
- On acceptance: push the entry and set wr_ack_q. Next cycle up_data_ok=1; up_rdata is don't-care (driven 0).
- When full, addr_ok stays 0 and the master holds req.
- Push and pop in the same cycle: count unchanged. Push is allowed when full only if a pop occurs in the same cycle? No — full blocks push regardless, which keeps the logic simple.

Upstream reads:
- Accepted only when all hold: state==IDLE, ~wr_ack_q, ~rd_pend, and no conflict.
- Conflict (default): FIFO not empty.
- On acceptance, the read is forwarded combinationally: dn_req=1, dn_wr=0, address and size passed through, up_addr_ok = dn_addr_ok.
- On dn_addr_ok: go to READ_WAIT and set rd_pend.
- On dn_data_ok in READ_WAIT: up_data_ok=1, up_rdata=dn_rdata, clear rd_pend, go to IDLE.

Drain FSM (one downstream transaction outstanding at a time):
- IDLE:
  - If an upstream read is eligible, it has priority.
  - Else if the FIFO is not empty, go to DRAIN.
- DRAIN:
  - dn_req=1, dn_wr=1; addr/size/wdata taken from the head entry.
  - On dn_addr_ok: go to DRAIN_WAIT. The head is not popped yet.
- DRAIN_WAIT:
  - dn_req=0.
  - On dn_data_ok: pop the head and go to IDLE.
- READ_WAIT: as described under Upstream reads.

Ordering:
- Stores reach memory in program order.
- A read never passes a store to the same word; the default mode makes it never pass any store.
- up_data_ok pulses are never simultaneous: a write ack is one cycle after its addr_ok, and reads are blocked while wr_ack_q is set.

Simultaneous events:
- Push during DRAIN_WAIT pop: count unchanged, pointers both advance.
- Push with empty FIFO in IDLE: drain starts the following cycle.

buf_empty = empty & (state==IDLE) & ~wr_ack_q.

Optional Feature:
- Macro: DWB_ADDR_CHECK_EN
- Defined:
  - Conflict = any valid entry, or the in-flight drain entry, with addr[31:2] equal to up_addr[31:2].
  - A non-conflicting read in IDLE bypasses the buffered stores and is issued ahead of the drain.
  - A conflicting read waits until the matching entries are drained.
- Undefined:
  - Conflict = FIFO not empty; reads wait for a full drain.
  - No comparators are built.

Test Plan:
- Reset, then a single word store: addr 0x0000_1000, data 0xDEADBEEF → up_addr_ok same cycle, up_data_ok next cycle. dn_req with wr=1, addr 0x1000 appears the cycle after acceptance. buf_empty=1 after dn_data_ok.
- 9 back-to-back stores with DEPTH=8 and dn_addr_ok held 0 → 8 accepted, 9th held with up_addr_ok=0 until the first drain completes. Downstream order is 0..8 with correct data; pointers wrap.
- Store to 0x2000 then read 0x2000, downstream latency 3 cycles → read is not issued downstream until the store's dn_data_ok. rdata returns the stored value; data_ok pulses are in order write, read.
- With DWB_ADDR_CHECK_EN: 3 stores queued at 0x3000–0x3008 and a read at 0x4000 → read issued first once state is IDLE. A read at 0x3004 waits until the entry at 0x3004 has retired.
- Byte store with size=0, addr 0x1F, data 0x000000AA → dn_size=0, dn_addr=0x1F, dn_wdata unchanged.
- rst asserted in DRAIN_WAIT with 4 entries queued → next cycle dn_req=0, buf_empty=1, count 0. A new store after reset drains normally.
